// File: rtl/ledseg_switch_debounce.sv
// Slide-switch conditioner: 2-FF sync plus per-bit stability debounce.
// Define SW_DEBOUNCE_EDGE_EN to add per-bit rise/fall strobes.
module ledseg_switch_debounce #(
  parameter int WIDTH   = 8,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
`ifdef SW_DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic             changed
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] sw_out_q, sw_out_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] upd;

  always_comb begin
    s1_d     = sw_raw;
    s2_d     = s1_q;
    sw_out_d = sw_out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] == sw_out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == LAST) begin
        sw_out_d[i] = s2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    upd       = sw_out_d ^ sw_out_q;
    changed_d = |upd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_out_q  <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sw_out_q  <= sw_out_d;
      changed_q <= changed_d;
      for (int i = 0; i < WIDTH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_out  = sw_out_q;
  assign changed = changed_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  // Strobes line up with changed: same edge, same cycle.
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  always_comb begin
    rise_d = upd & sw_out_d;
    fall_d = upd & ~sw_out_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_ledseg_switch_debounce.sv
// Bench for ledseg_switch_debounce with CNT_MAX=4.
// Reference model: sliding window of synchronized samples.
module tb_ledseg_switch_debounce;

  localparam int W    = 8;
  localparam int CMAX = 4;
  localparam int CW   = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_out;
  logic         changed;
  logic [W-1:0] rise, fall;

  int n_tests = 0;
  int n_fail  = 0;

  ledseg_switch_debounce #(
    .WIDTH(W), .CNT_MAX(CMAX), .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_raw  (sw_raw),
    .sw_out  (sw_out),
`ifdef SW_DEBOUNCE_EDGE_EN
    .rise    (rise),
    .fall    (fall),
`endif
    .changed (changed)
  );

`ifndef SW_DEBOUNCE_EDGE_EN
  assign rise = '0;
  assign fall = '0;
`endif

  always #5 clk = ~clk;

  // model state
  logic [W-1:0] m_s1, m_s2;
  logic [W-1:0] win[$];
  logic [W-1:0] e_out, e_rise, e_fall;
  logic         e_chg;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    win.delete();
    e_out = '0; e_rise = '0;
    e_fall = '0; e_chg = 1'b0;
  endtask

  // Advance one edge; out[i] flips once the last CMAX
  // synchronized samples all disagree with it.
  task automatic step();
    logic all;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      win.push_back(m_s2);
      if (win.size() > CMAX) void'(win.pop_front());
      e_rise = '0; e_fall = '0;
      if (win.size() == CMAX)
        for (int i = 0; i < W; i++) begin
          all = 1'b1;
          foreach (win[j])
            if (win[j][i] == e_out[i]) all = 1'b0;
          if (all) begin
            e_out[i] = ~e_out[i];
            if (e_out[i]) e_rise[i] = 1'b1;
            else          e_fall[i] = 1'b1;
          end
        end
      e_chg = |(e_rise | e_fall);
      m_s2 = m_s1;
      m_s1 = sw_raw;
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sw_raw  = 8'hFF;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      n_tests++;
      if (sw_out !== 8'h00 || changed !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: sw_out=%h chg=%b want 00/0",
                 sw_out, changed);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (sw_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_pre: sw_out=%h want ff", sw_out);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (sw_out !== 8'h00 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: sw_out=%h chg=%b want 00/0",
               sw_out, changed);
    end
    sw_raw = 8'h00;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    n_tests++;
    if (sw_out !== 8'h00 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rel_low: sw_out=%h chg=%b",
               sw_out, changed);
    end
  endtask

  task automatic test_latency();
    sw_raw = 8'h00;
    do_reset();
    sw_raw = 8'h01;
    for (int k = 1; k <= 5; k++) step();
    n_tests++;
    if (sw_out !== 8'h00) begin
      n_fail++;
      $display("FAIL lat_edge5: sw_out=%h want 00", sw_out);
    end
    step();
    n_tests++;
    if (sw_out !== 8'h01 || changed !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_edge6: sw_out=%h chg=%b want 01/1",
               sw_out, changed);
    end
    step();
    n_tests++;
    if (changed !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_pulse: chg=%b want 0", changed);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int flip_at;
    sw_raw = 8'h00;
    do_reset();
    // raw bits LSB first: 1,1,1,0,1,1,1,1 then held
    pat = 8'b1111_0111;
    flip_at = -1;
    for (int k = 0; k < 16; k++) begin
      sw_raw[0] = (k < 8) ? pat[k] : 1'b1;
      step();
      if (flip_at < 0 && sw_out[0]) flip_at = k + 1;
      n_tests++;
      if (sw_out !== e_out || changed !== e_chg) begin
        n_fail++;
        $display("FAIL bounce_model: e%0d sw_out=%h/%b want %h/%b",
                 k + 1, sw_out, changed, e_out, e_chg);
      end
    end
    // last dip sampled at edge 4; 1s from edge 5 on
    n_tests++;
    if (flip_at !== 10) begin
      n_fail++;
      $display("FAIL bounce_edge: flip at %0d want 10", flip_at);
    end
    sw_raw = 8'h00;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      sw_raw[0] = (k < 3);
      step();
    end
    n_tests++;
    if (sw_out !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch3: sw_out=%h want 00", sw_out);
    end
  endtask

  task automatic test_multi();
    int pulses;
    sw_raw = 8'h00;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    sw_raw = 8'hA5;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (changed === 1'b1) begin
        pulses++;
        n_tests++;
        if (sw_out !== 8'hA5) begin
          n_fail++;
          $display("FAIL multi_same: sw_out=%h want a5", sw_out);
        end
      end
    end
    n_tests++;
    if (pulses != 1 || sw_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL multi_pulse: pulses=%0d sw_out=%h want 1/a5",
               pulses, sw_out);
    end
  endtask

  task automatic test_reset_mid();
    sw_raw = 8'h00;
    do_reset();
    sw_raw = 8'h80;
    for (int k = 0; k < 4; k++) step();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (sw_out !== 8'h00 || changed !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear: sw_out=%h chg=%b", sw_out, changed);
    end
    step();
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    n_tests++;
    if (sw_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_early: sw_out=%h want 00", sw_out);
    end
    step();
    n_tests++;
    if (sw_out !== 8'h80 || changed !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_late: sw_out=%h chg=%b want 80/1",
               sw_out, changed);
    end
  endtask

  task automatic test_random();
    int hold;
    int bad;
    sw_raw = 8'h00;
    do_reset();
    hold = 0;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        sw_raw = sw_raw ^ 8'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      step();
      n_tests++;
      if (sw_out !== e_out || changed !== e_chg) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL rand: c%0d sw_out=%h/%b want %h/%b",
                   k, sw_out, changed, e_out, e_chg);
        bad++;
      end
`ifdef SW_DEBOUNCE_EDGE_EN
      n_tests++;
      if (rise !== e_rise || fall !== e_fall) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL rand_edge: r/f=%h/%h want %h/%h",
                   rise, fall, e_rise, e_fall);
        bad++;
      end
`endif
    end
  endtask

`ifdef SW_DEBOUNCE_EDGE_EN
  task automatic test_edges();
    int seen;
    sw_raw = 8'h0F;
    do_reset();
    for (int k = 0; k < 8; k++) step();
    sw_raw = 8'hF0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_tests++;
      if (changed) begin
        seen++;
        if (rise !== 8'hF0 || fall !== 8'h0F) begin
          n_fail++;
          $display("FAIL edges: r/f=%h/%h want f0/0f", rise, fall);
        end
      end else if (rise !== 8'h00 || fall !== 8'h00) begin
        n_fail++;
        $display("FAIL edges_idle: r/f=%h/%h want 0", rise, fall);
      end
    end
    n_tests++;
    if (seen != 1) begin
      n_fail++;
      $display("FAIL edges_cnt: pulses=%0d want 1", seen);
    end
  endtask
`endif

  initial begin
    model_reset();
    #1;
    test_reset();
    test_latency();
    test_bounce();
    test_multi();
    test_reset_mid();
`ifdef SW_DEBOUNCE_EDGE_EN
    test_edges();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
